// File: rtl/uart_tx_serializer_if.sv
// Upstream byte handshake into the UART transmitter's one-entry holding register.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one-entry holding register feeding a bit-timer FSM that
// frames each byte as start, LSB-first data and stop bits with no inter-frame gap.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_serializer_if.slave  s_in,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 r_ready;
  logic                 r_tx;
  logic                 r_busy;

  logic [1:0]           w_state_n;
  logic [BAUD_W-1:0]    w_baud_n;
  logic [BIT_W-1:0]     w_bit_n;
  logic [DATA_BITS-1:0] w_shift_n;
  logic [DATA_BITS-1:0] w_hold_n;
  logic                 w_hold_full_n;
  logic                 w_tx_n;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_baud_end;

  assign w_accept   = s_in.in_valid & r_ready;
  assign w_baud_end = (r_baud == BAUD_LAST);

  // tx_out is registered from the next-state line level, so the line changes
  // on the same edge as the state it belongs to.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_load    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_n = S_DATA;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_bit == DATA_LAST) begin
            w_state_n = S_STOP;
            w_bit_n   = '0;
            w_tx_n    = 1'b1;
          end else begin
            w_shift_n = {1'b0, r_shift[DATA_BITS-1:1]};
            w_bit_n   = r_bit + 1'b1;
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      default: begin
        // Stop bits reuse the bit counter to count STOP_BITS baud periods.
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_n = '0;
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_n = S_IDLE;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
    endcase

    if (w_load) begin
      w_state_n = S_START;
      w_shift_n = r_hold;
      w_baud_n  = '0;
      w_bit_n   = '0;
      w_tx_n    = 1'b0;
    end
  end

  always_comb begin
    w_hold_n      = r_hold;
    w_hold_full_n = r_hold_full;
    if (w_load) begin
      w_hold_full_n = 1'b0;
    end else if (w_accept) begin
      w_hold_full_n = 1'b1;
      w_hold_n      = s_in.in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_baud      <= w_baud_n;
      r_bit       <= w_bit_n;
      r_shift     <= w_shift_n;
      r_hold      <= w_hold_n;
      r_hold_full <= w_hold_full_n;
      r_ready     <= ~w_hold_full_n;
      r_tx        <= w_tx_n;
      r_busy      <= (w_state_n != S_IDLE) | w_hold_full_n;
    end
  end

  assign s_in.in_ready = r_ready;
  assign tx_out        = r_tx;
  assign busy          = r_busy;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-to-bitstream UART transmitter, 8N1 by default. Drives the single-bit `out` input of the registered-output iCE40 pin stage, which then drives the TX package pin.
- Upstream logic pushes bytes through a valid/ready handshake into a one-entry holding register.
- A bit-timer FSM shifts each byte out LSB-first, with start and stop framing.
- Back-to-back bytes go out with no idle gap.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit; legal range 2..65535 (217 = 25 MHz / 115200).
DATA_BITS, 8, data bits per frame; legal range 5..8.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clock  input  1  system clock; all state on its rising edge.
reset  input  1  asynchronous, active-high reset.
in_data  input  DATA_BITS  byte to transmit.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  holding register empty; a transfer occurs when in_valid & in_ready at a rising edge.
tx_out  output  1  serial line level; connects to the pin stage `out`. Idle high.
busy  output  1  high while a frame is in progress or the holding register is full.

Behaviour:
- Reset values (asynchronous on reset high):
  - tx_out = 1, in_ready = 1, busy = 0.
  - FSM = IDLE, holding register empty, bit counter and baud counter = 0.
- Outputs are registered:
  - tx_out is a flop; no combinational path from any input to tx_out.
  - in_ready = !hold_full, taken directly from a flop.
- Handshake:
  - A transfer at edge N sets hold_full and captures in_data.
  - in_ready drops after edge N.
  - in_data is ignored when in_ready is 0; no overwrite, no drop.
- FSM states IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1.
  - IDLE:
    - tx_out = 1.
    - If hold_full: load the shifter from hold, clear hold_full, zero the baud counter, go to START.
    - So tx_out = 0 after edge N+1 for a byte accepted at edge N into an idle block.
  - START:
    - tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx_out = shifter[0] for CLKS_PER_BIT cycles, then shift right.
    - After DATA_BITS bits, go to STOP.
  - STOP:
    - tx_out = 1 for STOP_BITS*CLKS_PER_BIT cycles.
    - At the final cycle, if hold_full: load from hold and go directly to START (no extra idle cycle).
    - Otherwise go to IDLE.
- Frame length: exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles. Continuous streaming yields back-to-back frames of exactly that period.
- Simultaneous load and accept:
  - The FSM load clears hold_full at edge M. in_ready rises after M, so a new byte can be accepted at edge M+1 at the earliest.
  - No same-edge load+accept, since in_ready was 0 at M.
- busy = (state != IDLE) | hold_full, registered.
  - Goes to 0 one cycle after STOP completes with hold empty.
- Reset mid-frame:
  - tx_out returns high immediately (asynchronous); the pending held byte is discarded.
  - The first frame after release starts only after a new handshake.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; bit counter is clog2(DATA_BITS+1) bits.
- Pin latency: the downstream pin stage adds one more clock, so the package pin lags tx_out by exactly 1 cycle.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated):
- Reset held, then released with in_valid=0 for 50 cycles:
  - tx_out=1, in_ready=1, busy=0 throughout.
- Single byte 0xA5 accepted at edge N:
  - tx_out=0 for cycles N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Then 1 for 4 cycles; busy falls after edge N+41.
- in_valid held high with 0x55 then 0x0F:
  - Second byte accepted one cycle after the first is loaded.
  - Second start bit begins immediately after the first stop bit, frame spacing exactly 40 cycles.
  - in_ready is low while hold is full.
- Backpressure: change in_data every cycle while in_ready=0:
  - The transmitted bytes equal only the handshaked values.
- Reset asserted mid-DATA of 0x00 (tx_out=0):
  - tx_out=1 within the same cycle (asynchronous) and in_ready=1.
  - After release, no frame is emitted without a new handshake.
- Parameter variant CLKS_PER_BIT=2, STOP_BITS=2, DATA_BITS=7, byte 0x7F:
  - Frame is 20 cycles: start 2 cycles, seven 1-bits of 2 cycles each, stop 4 cycles.
